bpm_button_ctrl: RTL and testbench
==================================

BPM_BUTTON_CTRL -- requirements
Module: bpm_button_ctrl

Interface
REQ-001 Parameters, SHALL be exactly: CLOCK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 DEBOUNCE_MS, default 10, time a raw level must stay stable before it is accepted.
REQ-003 REPEAT_DELAY_MS, default 500, hold time before auto-repeat starts.
REQ-004 REPEAT_PERIOD_MS, default 150, interval between auto-repeat pulses.
REQ-005 Ports SHALL be exactly:
- clk  input  1  system clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw, asynchronous, bouncy BPM-up button, active-high.
- btn_down  input  1  raw, asynchronous, bouncy BPM-down button, active-high.
- bpm_inc  output  1  registered one-cycle increment pulse, feeds the BPM clock bpm_inc.
- bpm_dec  output  1  registered one-cycle decrement pulse, feeds the BPM clock bpm_dec.
- btn_level  output  2  debounced levels, [0]=up, [1]=down, for LEDs.

Function
REQ-006 Each cycle count SHALL be CLOCK_FREQ/1000*ms, using integer math, clamped to a minimum of 1: D (debounce), R (repeat delay), P (repeat period).
REQ-007 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-008 Debounce SHALL work per button:
- A counter increments every cycle while the synchronized input differs from the debounced level.
- The counter clears in any cycle where they match.
- When the counter reaches D, the debounced level flips and the counter clears.
REQ-009 Latency: a clean raw 0->1 step first sampled at edge E0 SHALL make btn_level go high after edge E0+D+2 and the pulse go high after edge E0+D+3.
REQ-010 A per-button FSM SHALL have states IDLE, DELAY, REPEAT, LOCK. The shared LOCK state is entered from either FSM.
REQ-011 IDLE -> DELAY SHALL occur on a debounced rising edge while the other button's debounced level is low. The matching pulse is asserted for exactly 1 cycle.
REQ-012 In DELAY, a hold counter SHALL count cycles:
- At R cycles after the initial pulse: pulse once, clear the counter, go to REPEAT.
- On debounced release: go to IDLE with no pulse.
REQ-013 In REPEAT, the FSM SHALL pulse once every P cycles while held, and go to IDLE on release. No pulse is emitted in the release cycle.
REQ-014 Both debounced levels high in the same cycle SHALL send both FSMs to LOCK:
- bpm_inc and bpm_dec are held at 0.
- The FSMs stay in LOCK until both debounced levels are low, then return to IDLE.
- A pulse that would have fired in that cycle is suppressed.
REQ-015 bpm_inc and bpm_dec SHALL never both be high in the same cycle.
REQ-016 Each pulse SHALL last exactly one clk cycle, with at least one low cycle between consecutive pulses, including when P=1.
REQ-017 Raw glitches shorter than D synchronized cycles SHALL produce no change on btn_level and no pulse.
REQ-018 Hold counters SHALL saturate and never wrap. Widths come from $clog2 of max(R,P)+1 and $clog2(D+1).

Reset
REQ-019 reset SHALL take effect on the clk edge and do the following:
- Set synchronizers, debounced levels, counters and btn_level to 0.
- Put both FSMs in IDLE and drive bpm_inc and bpm_dec to 0.
REQ-020 If reset is asserted mid-pulse or mid-hold, the outputs SHALL be 0 in the next cycle. A button still held after reset deasserts SHALL count as a new press, after full debounce.

Structure
REQ-021 A shared package SHALL hold the FSM state typedef (IDLE, DELAY, REPEAT, LOCK) and a ms-to-cycles constant function.
REQ-022 One sub-module, button_debounce, SHALL be instantiated twice. It contains the synchronizer and debounce counter, outputs the debounced level, and takes D as a parameter.
REQ-023 The FSMs, lockout and pulse registers SHALL live in bpm_button_ctrl.

Verification
All scenarios use CLOCK_FREQ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_PERIOD_MS=3, giving D=4, R=10, P=3.
REQ-024 Clean press: btn_up goes high at E0 and is held 8 cycles -> btn_level[0] rises after E0+6, bpm_inc is high for exactly the 1 cycle after E0+7, bpm_dec stays 0.
REQ-025 Bounce: btn_down toggles every 2 cycles for 20 cycles, then stays low -> no bpm_dec pulse, btn_level[1] stays 0.
REQ-026 Auto-repeat: btn_up is held 30 cycles past the first pulse -> pulses at +0, +10, +13, +16, +19, +22, +25, +28; release -> no further pulses.
REQ-027 Lockout: btn_up is held, btn_down is pressed at first-pulse+2 -> no pulses at all once both are debounced high; after both release and a fresh btn_down press -> one bpm_dec pulse.
REQ-028 Reset mid-repeat: reset is asserted for 1 cycle while btn_up is held in REPEAT -> outputs 0 the next cycle; the next bpm_inc comes D+3 cycles after reset deasserts.

Source files
------------

// File: rtl/bpm_button_ctrl_pkg.sv
// Shared types and helpers for the BPM button controller.
// Holds the per-button FSM encoding and ms-to-cycle conversion.
package bpm_button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCK
    } btn_state_t;

    // Integer cycle count for a millisecond interval, never below one.
    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        int c;
        c = (freq_hz / 1000) * ms;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bpm_button_ctrl_debounce.sv
// Two-flop synchronizer plus stable-level debounce for one button.
// The level flips once the synchronized input has differed for D+1 cycles.
module button_debounce #(
    parameter int D = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] D_CNT = CW'(D);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == D_CNT) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/bpm_button_ctrl.sv
// Up/down BPM buttons: debounce, press pulse, auto-repeat, dual-press lockout.
// Index 0 is the up button, index 1 the down button.
module bpm_button_ctrl
    import bpm_button_ctrl_pkg::*;
#(
    parameter int CLOCK_FREQ       = 100_000_000,
    parameter int DEBOUNCE_MS      = 10,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       bpm_inc,
    output logic       bpm_dec,
    output logic [1:0] btn_level
);

    localparam int D  = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
    localparam int R  = ms_to_cycles(CLOCK_FREQ, REPEAT_DELAY_MS);
    localparam int P  = ms_to_cycles(CLOCK_FREQ, REPEAT_PERIOD_MS);
    localparam int HW = $clog2(max_int(R, P) + 1);

    localparam logic [HW-1:0] R_LAST = HW'(R - 1);
    localparam logic [HW-1:0] P_LAST = HW'(P - 1);
    localparam logic [HW-1:0] H_MAX  = '1;

    logic [1:0]    w_level;
    logic [1:0]    r_prev;
    logic [1:0]    w_rise;
    logic [1:0]    w_due;
    logic [1:0]    w_fire;
    logic [1:0]    w_out;
    logic          w_both;
    logic          r_inc;
    logic          r_dec;
    btn_state_t    r_state [2];
    btn_state_t    w_next  [2];
    logic [HW-1:0] r_hold  [2];

    button_debounce #(.D(D)) u_db_up (
        .i_clk   (clk),
        .i_reset (reset),
        .i_raw   (btn_up),
        .o_level (w_level[0])
    );

    button_debounce #(.D(D)) u_db_down (
        .i_clk   (clk),
        .i_reset (reset),
        .i_raw   (btn_down),
        .o_level (w_level[1])
    );

    assign w_both = w_level[0] & w_level[1];
    assign w_rise = w_level & ~r_prev;
    assign w_out  = {r_dec, r_inc};

    // A due pulse waits out a cycle if its own pulse is still high.
    always_comb begin
        w_due = '0;
        for (int i = 0; i < 2; i++) begin
            if (r_state[i] == DELAY)
                w_due[i] = (r_hold[i] >= R_LAST) & ~w_out[i];
            else if (r_state[i] == REPEAT)
                w_due[i] = (r_hold[i] >= P_LAST) & ~w_out[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_inc  <= 1'b0;
            r_dec  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= IDLE;
                r_hold[i]  <= '0;
            end
        end else begin
            r_prev <= w_level;
            r_inc  <= w_fire[0];
            r_dec  <= w_fire[1] & ~w_fire[0];
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_next[i];
                if (w_fire[i] || (w_next[i] != r_state[i]))
                    r_hold[i] <= '0;
                else if (r_hold[i] != H_MAX)
                    r_hold[i] <= r_hold[i] + HW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_next[i] = r_state[i];
            if (w_both) begin
                w_next[i] = LOCK;
            end else begin
                unique case (r_state[i])
                    IDLE:
                        if (w_rise[i]) w_next[i] = DELAY;
                    DELAY:
                        if (!w_level[i])  w_next[i] = IDLE;
                        else if (w_due[i]) w_next[i] = REPEAT;
                    REPEAT:
                        if (!w_level[i]) w_next[i] = IDLE;
                    LOCK:
                        if (w_level == 2'b00) w_next[i] = IDLE;
                    default:
                        w_next[i] = IDLE;
                endcase
            end
        end
    end

    // Release and lockout both take priority over a due pulse.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < 2; i++) begin
            unique case (r_state[i])
                IDLE:          w_fire[i] = w_rise[i];
                DELAY, REPEAT: w_fire[i] = w_level[i] & w_due[i];
                default:       w_fire[i] = 1'b0;
            endcase
        end
        if (w_both) w_fire = '0;
    end

    assign bpm_inc   = r_inc;
    assign bpm_dec   = r_dec;
    assign btn_level = w_level;

endmodule

// File: tb/tb_bpm_button_ctrl.sv
// Scoreboard bench for bpm_button_ctrl with D=4, R=10, P=3.
// Stimulus queues expected pulse cycles; a monitor pops them on each pulse.
module tb_bpm_button_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       bpm_inc;
    logic       bpm_dec;
    logic [1:0] btn_level;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int at;
        bit dec;
    } exp_t;

    exp_t sb[$];

    bpm_button_ctrl #(
        .CLOCK_FREQ       (1000),
        .DEBOUNCE_MS      (4),
        .REPEAT_DELAY_MS  (10),
        .REPEAT_PERIOD_MS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .bpm_inc   (bpm_inc),
        .bpm_dec   (bpm_dec),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive_at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic look_at(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic expect_pulse(input int t, input bit dec);
        exp_t e;
        e.at  = t;
        e.dec = dec;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b",
                     name, cyc, act, exp);
        end
    endtask

    // Pulse monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bpm_inc === 1'b1 || bpm_dec === 1'b1) begin
                checks++;
                if (bpm_inc && bpm_dec) begin
                    errors++;
                    $display("FAIL both_pulses at cycle %0d: inc=1 dec=1, expected one", cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse at cycle %0d: inc=%b dec=%b, expected none",
                             cyc, bpm_inc, bpm_dec);
                end else begin
                    e = sb.pop_front();
                    if (e.at != cyc || e.dec != bpm_dec) begin
                        errors++;
                        $display("FAIL pulse at cycle %0d dec=%b, expected cycle %0d dec=%b",
                                 cyc, bpm_dec, e.at, e.dec);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int p0;

        // Reset state
        look_at(2);
        chk("reset_level", btn_level, 2'b00);
        chk("reset_pulses", {bpm_dec, bpm_inc}, 2'b00);
        drive_at(3);
        reset = 1'b0;

        // Clean press held for 8 samples
        k = 10;
        drive_at(k);
        btn_up = 1'b1;
        expect_pulse(k + 8, 1'b0);
        look_at(k + 6);
        chk("clean_lvl_before", btn_level, 2'b00);
        look_at(k + 7);
        chk("clean_lvl_after", btn_level, 2'b01);
        drive_at(k + 8);
        btn_up = 1'b0;
        look_at(k + 16);
        chk("clean_lvl_release", btn_level, 2'b00);

        // Bounce on btn_down: 2-cycle toggles never debounce
        k = 40;
        for (int i = 0; i < 10; i++) begin
            drive_at(k + 2 * i);
            btn_down = (i % 2 == 0);
        end
        drive_at(k + 20);
        btn_down = 1'b0;
        look_at(k + 5);
        chk("bounce_lvl_a", btn_level, 2'b00);
        look_at(k + 11);
        chk("bounce_lvl_b", btn_level, 2'b00);
        look_at(k + 17);
        chk("bounce_lvl_c", btn_level, 2'b00);
        look_at(k + 25);
        chk("bounce_lvl_d", btn_level, 2'b00);

        // Auto-repeat: debounced level stays high to first pulse + 30
        k  = 80;
        p0 = k + 8;
        drive_at(k);
        btn_up = 1'b1;
        expect_pulse(p0, 1'b0);
        expect_pulse(p0 + 10, 1'b0);
        expect_pulse(p0 + 13, 1'b0);
        expect_pulse(p0 + 16, 1'b0);
        expect_pulse(p0 + 19, 1'b0);
        expect_pulse(p0 + 22, 1'b0);
        expect_pulse(p0 + 25, 1'b0);
        expect_pulse(p0 + 28, 1'b0);
        drive_at(p0 + 23);
        btn_up = 1'b0;
        look_at(p0 + 29);
        chk("repeat_lvl_held", btn_level, 2'b01);
        look_at(p0 + 30);
        chk("repeat_lvl_rel", btn_level, 2'b00);

        // Lockout: down pressed 2 cycles after the first up pulse
        k  = 140;
        p0 = k + 8;
        drive_at(k);
        btn_up = 1'b1;
        expect_pulse(p0, 1'b0);
        drive_at(p0 + 2);
        btn_down = 1'b1;
        look_at(p0 + 8);
        chk("lock_lvl_up", btn_level, 2'b01);
        look_at(p0 + 9);
        chk("lock_lvl_both", btn_level, 2'b11);
        look_at(p0 + 15);
        chk("lock_lvl_hold", btn_level, 2'b11);
        drive_at(p0 + 20);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        look_at(p0 + 28);
        chk("lock_lvl_rel", btn_level, 2'b00);
        drive_at(p0 + 40);
        btn_down = 1'b1;
        expect_pulse(p0 + 48, 1'b1);
        drive_at(p0 + 49);
        btn_down = 1'b0;
        look_at(p0 + 52);
        chk("lock_lvl_down", btn_level, 2'b10);

        // Reset while in REPEAT, button kept held
        k  = 220;
        p0 = k + 8;
        drive_at(k);
        btn_up = 1'b1;
        expect_pulse(p0, 1'b0);
        expect_pulse(p0 + 10, 1'b0);
        expect_pulse(p0 + 13, 1'b0);
        drive_at(p0 + 15);
        reset = 1'b1;
        look_at(p0 + 16);
        chk("rst_pulses", {bpm_dec, bpm_inc}, 2'b00);
        chk("rst_lvl", btn_level, 2'b00);
        drive_at(p0 + 16);
        reset = 1'b0;
        expect_pulse(p0 + 24, 1'b0);
        look_at(p0 + 22);
        chk("rst_relvl_before", btn_level, 2'b00);
        look_at(p0 + 23);
        chk("rst_relvl_after", btn_level, 2'b01);
        drive_at(p0 + 25);
        btn_up = 1'b0;

        look_at(p0 + 50);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d still queued, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
